// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI receive path: APB register offsets,
// status bit positions and the deserializer state encoding.
package spi_pkg;

  localparam int REGRX_OFFSET_DFLT     = 'h08;
  localparam int REGSTATUS_OFFSET_DFLT = 'h04;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_UND   = 3;
  localparam int ST_FERR  = 4;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive FIFO: power-of-two ring buffer with a separate occupancy counter so
// full and empty stay distinguishable when the pointers coincide.
module spi_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(FIFO_DEPTH):0]   cnt,
  output logic                          empty,
  output logic                          full,
  output logic                          overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt_r;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (cnt_r == '0);
  assign full    = (cnt_r == CNT_W'(FIFO_DEPTH));
  assign cnt     = cnt_r;
  assign dout    = mem[rd_ptr];

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign overrun = push & full & ~pop_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_r  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_rx_path.sv
// SPI receive path: MISO deserializer, RX FIFO, sticky error flags and the
// APB read/status port that drains them.
module spi_rx_path
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] REGRX_ADDR_OFFSET     = ADDR_WIDTH'(REGRX_OFFSET_DFLT),
  parameter logic [ADDR_WIDTH-1:0] REGSTATUS_ADDR_OFFSET = ADDR_WIDTH'(REGSTATUS_OFFSET_DFLT)
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_WIDTH-1:0]       PADDR,
  input  logic [31:0]                 PWDATA,
  output logic [31:0]                 PRDATA,
  output logic                        PREADY,
  input  logic                        CS_N,
  input  logic                        SAMPLE,
  input  logic                        MISO,
  output logic [$clog2(FIFO_DEPTH):0] CNT,
  output logic                        EMPTY,
  output logic                        FULL,
  output logic                        RX_IRQ
);

  localparam int BC_W = $clog2(DATA_WIDTH);

  rx_state_t             state;
  logic [BC_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] head;
  logic                  sample_en;
  logic                  last_bit;
  logic                  push;
  logic                  pop;
  logic                  ovr_pulse;
  logic                  ferr_set;
  logic                  und_set;
  logic                  rd_access;
  logic                  wr_access;
  logic                  sel_rx;
  logic                  sel_st;
  logic [2:0]            sticky;
  logic [2:0]            sticky_set;
  logic [2:0]            sticky_clr;
  logic                  unused_pwdata;

  assign PREADY    = 1'b1;
  assign rd_access = PSEL & PENABLE & ~PWRITE;
  assign wr_access = PSEL & PENABLE & PWRITE;
  assign sel_rx    = (PADDR == REGRX_ADDR_OFFSET);
  assign sel_st    = (PADDR == REGSTATUS_ADDR_OFFSET);

  // The completing sample pushes straight from the wire so the byte lands in
  // the FIFO on the same edge as the last bit.
  assign sample_en = (state == SHIFT) & ~CS_N & SAMPLE;
  assign last_bit  = (bit_cnt == BC_W'(DATA_WIDTH - 1));
  assign din       = {shreg[DATA_WIDTH-2:0], MISO};
  assign push      = sample_en & last_bit;
  assign ferr_set  = (state == SHIFT) & CS_N & (bit_cnt != '0);

  assign pop       = rd_access & sel_rx & ~EMPTY;
  assign und_set   = rd_access & sel_rx & EMPTY;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!CS_N) state <= SHIFT;
        end
        SHIFT: begin
          if (CS_N) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (SAMPLE) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + BC_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (sample_en) shreg <= din;
  end

  spi_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (PCLK),
    .rst     (PRESET),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .dout    (head),
    .cnt     (CNT),
    .empty   (EMPTY),
    .full    (FULL),
    .overrun (ovr_pulse)
  );

  // Sticky flags ordered {frame error, underrun, overrun} to line up with the
  // W1C field; a new event wins over a clear landing on the same edge.
  assign sticky_set = {ferr_set, und_set, ovr_pulse};
  assign sticky_clr = (wr_access & sel_st) ? PWDATA[ST_FERR:ST_OVR] : 3'b000;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sticky <= '0;
      RX_IRQ <= 1'b0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | sticky_set;
      RX_IRQ <= ~EMPTY | (|sticky);
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd_access) begin
      if (sel_rx) begin
        if (!EMPTY) PRDATA = 32'(head);
      end else if (sel_st) begin
        PRDATA[ST_EMPTY] = EMPTY;
        PRDATA[ST_FULL]  = FULL;
        PRDATA[ST_OVR]   = sticky[0];
        PRDATA[ST_UND]   = sticky[1];
        PRDATA[ST_FERR]  = sticky[2];
        PRDATA[15:8]     = 8'(CNT);
      end
    end
  end

  assign unused_pwdata = ^{PWDATA[31:5], PWDATA[1:0]};

endmodule

// File: tb/tb_spi_rx_path.sv
// Scoreboard bench for spi_rx_path: a queue-based model predicts every APB read
// and a free-running monitor compares PRDATA whenever an access phase occurs.
module tb_spi_rx_path;

  localparam int DEPTH = 8;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, CS_N, SAMPLE, MISO;
  logic [3:0]  CNT;
  logic        EMPTY, FULL, RX_IRQ;

  always #5 PCLK = ~PCLK;

  spi_rx_path dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .CS_N    (CS_N),
    .SAMPLE  (SAMPLE),
    .MISO    (MISO),
    .CNT     (CNT),
    .EMPTY   (EMPTY),
    .FULL    (FULL),
    .RX_IRQ  (RX_IRQ)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mq[$];
  logic [31:0] exp_q[$];
  bit          m_ovr, m_und, m_ferr;
  int          mbits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() == 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = m_und;
    s[4] = m_ferr;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_read(input logic [7:0] addr);
    logic [31:0] e;
    if (addr == 8'h08) begin
      if (mq.size() == 0) begin
        e = 0;
        m_und = 1'b1;
      end else begin
        e = {24'b0, mq.pop_front()};
      end
    end else if (addr == 8'h04) begin
      e = model_status();
    end else begin
      e = 0;
    end
    exp_q.push_back(e);
    PSEL = 1'b1; PADDR = addr; PWRITE = 1'b0; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    if (addr == 8'h04) begin
      if (data[2]) m_ovr  = 1'b0;
      if (data[3]) m_und  = 1'b0;
      if (data[4]) m_ferr = 1'b0;
    end
    PSEL = 1'b1; PADDR = addr; PWRITE = 1'b1; PWDATA = data; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
  endtask

  task automatic shift_bits(input logic [7:0] b, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          SAMPLE = 1'b0;
          tick();
        end
      end
      SAMPLE = 1'b1;
      MISO   = b[7-i];
      tick();
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        model_push(b);
      end
    end
    SAMPLE = 1'b0;
    MISO   = 1'b0;
  endtask

  task automatic cs_low();
    CS_N = 1'b0;
    tick();
  endtask

  task automatic cs_high();
    CS_N = 1'b1;
    tick();
    if (mbits != 0) m_ferr = 1'b1;
    mbits = 0;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    tick();
    tick();
    PRESET = 1'b0;
    mq.delete();
    m_ovr = 0; m_und = 0; m_ferr = 0;
    mbits = 0;
  endtask

  task automatic check_outputs(input string tag);
    SAMPLE = 1'b0;
    tick();
    tick();
    chk({tag, "_cnt"},   32'(CNT),    32'(mq.size()));
    chk({tag, "_empty"}, 32'(EMPTY),  32'(mq.size() == 0));
    chk({tag, "_full"},  32'(FULL),   32'(mq.size() == DEPTH));
    chk({tag, "_irq"},   32'(RX_IRQ), 32'((mq.size() != 0) || m_ovr || m_und || m_ferr));
  endtask

  // Last bit of a frame lands on the same edge as a REGRX pop.
  task automatic pop_with_push(input logic [7:0] b);
    shift_bits(b, 7, 1'b0);
    PSEL = 1'b1; PADDR = 8'h08; PWRITE = 1'b0; PENABLE = 1'b0;
    tick();
    exp_q.push_back({24'b0, mq.pop_front()});
    PENABLE = 1'b1;
    SAMPLE  = 1'b1;
    MISO    = b[0];
    tick();
    mbits = 0;
    model_push(b);
    PSEL = 1'b0; PENABLE = 1'b0; SAMPLE = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE && !PWRITE) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got 'h%0h with empty scoreboard", PRDATA);
        end else begin
          chk("prdata", PRDATA, exp_q.pop_front());
        end
      end else if (!PRESET) begin
        chk("prdata_idle", PRDATA, 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int op;
    PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    CS_N = 1'b1; SAMPLE = 0; MISO = 0;
    m_ovr = 0; m_und = 0; m_ferr = 0; mbits = 0;
    do_reset();

    check_outputs("reset");
    chk("reset_pready", 32'(PREADY), 32'h1);
    apb_read(8'h04);
    apb_read(8'h08);
    apb_read(8'h04);
    apb_write(8'h04, 32'h08);
    apb_read(8'h04);

    cs_low();
    shift_bits(8'hA5, 8, 1'b0);
    check_outputs("one_byte");
    apb_read(8'h08);
    check_outputs("one_byte_drained");

    for (int i = 1; i <= 9; i++) shift_bits(8'(i), 8, 1'b1);
    check_outputs("overrun");
    apb_read(8'h04);
    for (int i = 0; i < 8; i++) apb_read(8'h08);
    apb_write(8'h04, 32'h04);
    shift_bits(8'h55, 8, 1'b0);
    apb_read(8'h08);
    check_outputs("wrap");

    for (int i = 0; i < 8; i++) shift_bits(8'($urandom), 8, 1'b0);
    pop_with_push(8'hC3);
    check_outputs("full_push_pop");
    apb_read(8'h04);
    for (int i = 0; i < 8; i++) apb_read(8'h08);

    shift_bits(8'h9A, 5, 1'b0);
    cs_high();
    check_outputs("frame_err");
    apb_read(8'h04);
    cs_low();
    shift_bits(8'h3C, 8, 1'b0);
    apb_read(8'h08);
    apb_write(8'h04, 32'h1C);

    for (int i = 0; i < 3; i++) shift_bits(8'($urandom), 8, 1'b0);
    shift_bits(8'hF0, 4, 1'b0);
    do_reset();
    apb_read(8'h04);
    check_outputs("mid_frame_reset");
    cs_high();
    cs_low();
    shift_bits(8'h7E, 8, 1'b0);
    apb_read(8'h08);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      r  = 8'($urandom);
      case (op)
        0, 1, 2: shift_bits(r, 8, 1'b1);
        3, 4:    apb_read(8'h08);
        5:       apb_read(8'h04);
        6:       apb_write(8'h04, {27'b0, r[4:2], 2'b0});
        7: begin
          shift_bits(r, $urandom_range(1, 7), 1'b1);
          cs_high();
          cs_low();
        end
        8: begin
          case ($urandom_range(0, 2))
            0:       apb_read(8'h00);
            1:       apb_read(8'h0C);
            default: apb_write(8'h08, 32'(r));
          endcase
        end
        default: check_outputs("random");
      endcase
    end

    cs_high();
    apb_read(8'h04);
    while (mq.size() != 0) apb_read(8'h08);
    check_outputs("final");
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
